// File: rtl/prbs_pkg.sv
// Shared PRBS31 definitions (x^31 + x^28 + 1) used by both the generator and the checker.
package prbs_pkg;

    localparam int PRBS31_LEN = 31;
    localparam int TAP_A      = 30;
    localparam int TAP_B      = 27;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/prbs31_step.sv
// One combinational PRBS31 step: predicted feedback bit and the register after shifting it in at bit 0.
module prbs31_step
    import prbs_pkg::*;
(
    input  logic [PRBS31_LEN-1:0] cur,
    output logic [PRBS31_LEN-1:0] nxt,
    output logic                  pred
);

    assign pred = cur[TAP_A] ^ cur[TAP_B];
    assign nxt  = {cur[PRBS31_LEN-2:0], pred};

endmodule

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 receiver/verifier with lock detection and windowed error monitoring.
// Optional: define PRBS_CHK_INVERT_EN to accept the complemented PRBS31 stream.
module prbs31_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_COUNT = 62,
    parameter int WINDOW     = 64,
    parameter int ERR_THRESH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             CLK_50M,
    input  logic             RST,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [7:0]       LED
);

    localparam int FILL_W  = $clog2(PRBS31_LEN + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);
    localparam int ERR_W   = $clog2(ERR_THRESH + 1);

    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PRBS31_LEN);
    localparam logic [MATCH_W-1:0] LOCK_MAX  = MATCH_W'(LOCK_COUNT);
    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [ERR_W-1:0]   ERR_MAX   = ERR_W'(ERR_THRESH);

    state_t                  state,     state_n;
    logic [PRBS31_LEN-1:0]   chk_reg,   chk_n;
    logic [FILL_W-1:0]       fill_cnt,  fill_n;
    logic [MATCH_W-1:0]      match_cnt, match_n, match_inc;
    logic [WIN_W-1:0]        win_bits,  win_bits_n;
    logic [ERR_W-1:0]        win_err,   win_err_n, win_err_inc;
    logic [CNT_W-1:0]        err_count_n;
    logic                    err_pulse_n;
    logic [PRBS31_LEN-1:0]   step_nxt;
    logic [PRBS31_LEN-1:0]   shift_in;
    logic                    pred;
    logic                    bit_eff;
    logic                    miss;

`ifdef PRBS_CHK_INVERT_EN
    assign bit_eff = ~bit_in;
`else
    assign bit_eff = bit_in;
`endif

    prbs31_step u_step (
        .cur  (chk_reg),
        .nxt  (step_nxt),
        .pred (pred)
    );

    assign miss        = bit_eff ^ pred;
    assign shift_in    = {chk_reg[PRBS31_LEN-2:0], bit_eff};
    assign match_inc   = (match_cnt == LOCK_MAX) ? LOCK_MAX : match_cnt + MATCH_W'(1);
    assign win_err_inc = win_err + ERR_W'(miss);

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_n     = state;
        chk_n       = chk_reg;
        fill_n      = fill_cnt;
        match_n     = match_cnt;
        win_bits_n  = win_bits;
        win_err_n   = win_err;
        err_count_n = err_count;
        err_pulse_n = 1'b0;

        if (bit_valid) begin
            case (state)
                SEARCH: begin
                    chk_n = shift_in;
                    if (fill_cnt != FILL_FULL) begin
                        fill_n = fill_cnt + FILL_W'(1);
                    end else if (miss) begin
                        match_n = '0;
                    end else begin
                        match_n = match_inc;
                        // All-zero register would predict zeros forever; a dead line must not lock.
                        if (match_inc == LOCK_MAX && shift_in != '0)
                            state_n = LOCKED;
                    end
                end
                LOCKED: begin
                    chk_n = step_nxt;
                    if (miss) begin
                        err_pulse_n = 1'b1;
                        if (err_count != '1)
                            err_count_n = err_count + CNT_W'(1);
                    end
                    if (win_err_inc == ERR_MAX) begin
                        state_n    = SEARCH;
                        chk_n      = shift_in;
                        fill_n     = '0;
                        match_n    = '0;
                        win_bits_n = '0;
                        win_err_n  = '0;
                    end else if (win_bits == WIN_LAST) begin
                        win_bits_n = '0;
                        win_err_n  = '0;
                    end else begin
                        win_bits_n = win_bits + WIN_W'(1);
                        win_err_n  = win_err_inc;
                    end
                end
                default: state_n = SEARCH;
            endcase
        end

        if (err_clr)
            err_count_n = '0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            state     <= SEARCH;
            chk_reg   <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_bits  <= '0;
            win_err   <= '0;
            err_count <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            chk_reg   <= chk_n;
            fill_cnt  <= fill_n;
            match_cnt <= match_n;
            win_bits  <= win_bits_n;
            win_err   <= win_err_n;
            err_count <= err_count_n;
            err_pulse <= err_pulse_n;
        end
    end

    assign locked = (state == LOCKED);
    assign LED    = chk_reg[7:0];

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: a PRBS31 generator model feeds bit_in, one bit_valid every 4 clocks.
module tb_prbs31_checker;

`ifdef PRBS_CHK_INVERT_EN
    localparam logic POL = 1'b1;
`else
    localparam logic POL = 1'b0;
`endif

    logic        CLK_50M;
    logic        RST;
    logic        bit_in;
    logic        bit_valid;
    logic        err_clr;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [7:0]  LED;

    int          vectors;
    int          miscompares;
    int          pulse_cnt;
    logic        last_pulse;
    logic [30:0] gen;

    prbs31_checker dut (
        .CLK_50M   (CLK_50M),
        .RST       (RST),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .err_clr   (err_clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .LED       (LED)
    );

    initial CLK_50M = 1'b0;
    always #10 CLK_50M = ~CLK_50M;

    task automatic send_bit(input logic b, input logic clr);
        @(negedge CLK_50M);
        bit_in    = b;
        bit_valid = 1'b1;
        err_clr   = clr;
        @(negedge CLK_50M);
        bit_valid  = 1'b0;
        err_clr    = 1'b0;
        last_pulse = err_pulse;
        if (err_pulse === 1'b1) pulse_cnt++;
        @(negedge CLK_50M);
        @(negedge CLK_50M);
    endtask

    // Generator model: feedback bit becomes the new bit 0 and is the transmitted bit.
    task automatic send_gen(input logic flip, input logic clr);
        logic fb;
        fb  = gen[30] ^ gen[27];
        gen = {gen[29:0], fb};
        send_bit(fb ^ flip ^ POL, clr);
    endtask

    task automatic do_reset();
        bit_valid = 1'b0;
        err_clr   = 1'b0;
        bit_in    = 1'b0;
        RST       = 1'b1;
        repeat (2) @(negedge CLK_50M);
        RST = 1'b0;
        @(negedge CLK_50M);
        pulse_cnt = 0;
    endtask

    task automatic expect_lock_after_93(input string name);
        repeat (92) send_gen(1'b0, 1'b0);
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_early: locked=%b required 0 after 92 bits", name, locked);
        end
        send_gen(1'b0, 1'b0);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_lock: locked=%b required 1 after 93 bits", name, locked);
        end
    endtask

    task automatic relock();
        do_reset();
        gen = 31'd1;
        expect_lock_after_93("relock");
        pulse_cnt = 0;
    endtask

    task automatic test_reset();
        RST       = 1'b0;
        bit_valid = 1'b0;
        err_clr   = 1'b0;
        bit_in    = 1'b0;
        #3 RST = 1'b1;
        #2;
        vectors++;
        if ({locked, err_pulse, err_count, LED} !== 26'd0) begin
            miscompares++;
            $display("FAIL reset_state: locked=%b pulse=%b cnt=%0d led=%h required all 0",
                     locked, err_pulse, err_count, LED);
        end
        repeat (2) @(negedge CLK_50M);
        RST = 1'b0;
        @(negedge CLK_50M);
    endtask

    task automatic test_lock();
        do_reset();
        gen = 31'd1;
        expect_lock_after_93("lock");
        vectors++;
        if (err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL lock_errcnt: err_count=%0d required 0", err_count);
        end
        for (int i = 0; i < 20; i++) begin
            send_gen(1'b0, 1'b0);
            vectors++;
            if (LED !== gen[7:0]) begin
                miscompares++;
                $display("FAIL lock_led[%0d]: LED=%h required %h", i, LED, gen[7:0]);
            end
        end
    endtask

    task automatic test_single_error();
        relock();
        send_gen(1'b1, 1'b0);
        vectors++;
        if (last_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL single_err: pulse=%b cnt=%0d locked=%b required 1/1/1",
                     last_pulse, err_count, locked);
        end
        repeat (10) send_gen(1'b0, 1'b0);
        vectors++;
        if (pulse_cnt != 1 || locked !== 1'b1 || LED !== gen[7:0]) begin
            miscompares++;
            $display("FAIL single_err_after: pulses=%0d locked=%b LED=%h required 1/1/%h",
                     pulse_cnt, locked, LED, gen[7:0]);
        end
    endtask

    task automatic test_lose_lock();
        relock();
        for (int k = 1; k <= 16; k++) begin
            send_gen(k % 2 == 0, 1'b0);
            if (k == 14) begin
                vectors++;
                if (locked !== 1'b1) begin
                    miscompares++;
                    $display("FAIL lose_lock_7: locked=%b required 1 after 7 errors", locked);
                end
            end
        end
        vectors++;
        if (locked !== 1'b0 || err_count !== 16'd8 || pulse_cnt != 8) begin
            miscompares++;
            $display("FAIL lose_lock_8: locked=%b cnt=%0d pulses=%0d required 0/8/8",
                     locked, err_count, pulse_cnt);
        end
        expect_lock_after_93("relock_after_loss");
        vectors++;
        if (err_count !== 16'd8) begin
            miscompares++;
            $display("FAIL lose_lock_hold: err_count=%0d required 8", err_count);
        end
    endtask

    task automatic test_two_windows();
        relock();
        for (int k = 1; k <= 130; k++)
            send_gen(((k >= 10 && k <= 22) || (k >= 70 && k <= 82)) && (k % 2 == 0), 1'b0);
        vectors++;
        if (locked !== 1'b1 || err_count !== 16'd14 || pulse_cnt != 14) begin
            miscompares++;
            $display("FAIL two_windows: locked=%b cnt=%0d pulses=%0d required 1/14/14",
                     locked, err_count, pulse_cnt);
        end
    endtask

    task automatic test_stuck_line();
        logic seen;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            send_bit(POL, 1'b0);
            if (locked === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0 || err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL stuck_line: ever_locked=%b cnt=%0d required 0/0", seen, err_count);
        end
    endtask

    task automatic test_err_clr();
        relock();
        for (int k = 1; k <= 9; k++) send_gen(k % 2 == 1, 1'b0);
        vectors++;
        if (err_count !== 16'd5) begin
            miscompares++;
            $display("FAIL err_clr_pre: err_count=%0d required 5", err_count);
        end
        send_gen(1'b1, 1'b1);
        vectors++;
        if (err_count !== 16'd0 || last_pulse !== 1'b1) begin
            miscompares++;
            $display("FAIL err_clr_wins: cnt=%0d pulse=%b required 0/1", err_count, last_pulse);
        end
    endtask

    task automatic test_async_reset();
        logic fb;
        relock();
        for (int k = 1; k <= 6; k++) send_gen(k % 2 == 0, 1'b0);
        vectors++;
        if (err_count !== 16'd3 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL async_pre: cnt=%0d locked=%b required 3/1", err_count, locked);
        end
        fb  = gen[30] ^ gen[27];
        gen = {gen[29:0], fb};
        @(negedge CLK_50M);
        bit_in    = ~fb ^ POL;
        bit_valid = 1'b1;
        @(posedge CLK_50M);
        #2;
        vectors++;
        if (err_pulse !== 1'b1 || err_count !== 16'd4) begin
            miscompares++;
            $display("FAIL async_err: pulse=%b cnt=%0d required 1/4", err_pulse, err_count);
        end
        RST = 1'b1;
        #1;
        vectors++;
        if ({locked, err_pulse, err_count, LED} !== 26'd0) begin
            miscompares++;
            $display("FAIL async_reset: locked=%b pulse=%b cnt=%0d led=%h required all 0",
                     locked, err_pulse, err_count, LED);
        end
        @(negedge CLK_50M);
        bit_valid = 1'b0;
        repeat (2) @(negedge CLK_50M);
        RST = 1'b0;
        @(negedge CLK_50M);
        expect_lock_after_93("relock_after_rst");
        vectors++;
        if (err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL async_relock_cnt: err_count=%0d required 0", err_count);
        end
    endtask

    task automatic test_wrong_polarity();
        logic seen;
        do_reset();
        gen  = 31'd1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            send_gen(1'b1, 1'b0);
            if (locked === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL wrong_polarity: ever_locked=%b required 0", seen);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pulse_cnt   = 0;
        last_pulse  = 1'b0;
        gen         = 31'd1;
        test_reset();
        test_lock();
        test_single_error();
        test_lose_lock();
        test_two_windows();
        test_stuck_line();
        test_err_clr();
        test_async_reset();
        test_wrong_polarity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
